// File: rtl/seq_detect_ctrl.sv
// Run-control and configuration block for a programmable serial pattern detector.
// Optional macro FIRST_MATCH_POS_EN adds first_pos / first_pos_valid outputs.
module seq_detect_ctrl #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_threshold,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             start,
    input  logic             stop,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             done,
    output logic             threshold_hit
`ifdef FIRST_MATCH_POS_EN
    ,
    output logic [WIN_W-1:0] first_pos,
    output logic             first_pos_valid
`endif
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic               pulse_q, pulse_d;
    logic               thr_hit_q, thr_hit_d;
    logic [PAT_W-1:0]   cfg_pat_q, cfg_pat_d;
    logic               cfg_ov_q, cfg_ov_d;
    logic [CNT_W-1:0]   cfg_thr_q, cfg_thr_d;
    logic [WIN_W-1:0]   cfg_win_q, cfg_win_d;
`ifdef FIRST_MATCH_POS_EN
    logic [WIN_W-1:0]   fpos_q, fpos_d;
    logic               fpos_vld_q, fpos_vld_d;
`endif

    logic [PAT_W-1:0]   shift_w;
    logic               hit;
    logic               thr_reached;
    logic               win_reached;

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        win_cnt_d   = win_cnt_q;
        pulse_d     = 1'b0;
        thr_hit_d   = thr_hit_q;
        cfg_pat_d   = cfg_pat_q;
        cfg_ov_d    = cfg_ov_q;
        cfg_thr_d   = cfg_thr_q;
        cfg_win_d   = cfg_win_q;
`ifdef FIRST_MATCH_POS_EN
        fpos_d      = fpos_q;
        fpos_vld_d  = fpos_vld_q;
`endif
        shift_w     = {hist_q, bit_in};
        hit         = 1'b0;
        thr_reached = 1'b0;
        win_reached = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_we) begin
                    cfg_pat_d = cfg_pattern;
                    cfg_ov_d  = cfg_overlap;
                    cfg_thr_d = cfg_threshold;
                    cfg_win_d = cfg_window;
                end
                if (start) begin
                    state_d   = S_RUN;
                    hist_d    = '0;
                    fill_d    = '0;
                    cnt_d     = '0;
                    win_cnt_d = '0;
                    thr_hit_d = 1'b0;
`ifdef FIRST_MATCH_POS_EN
                    fpos_d     = '0;
                    fpos_vld_d = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (bit_valid) begin
                    hist_d    = shift_w[PAT_W-2:0];
                    fill_d    = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                    hit       = (shift_w == cfg_pat_q) && (fill_q >= FILL_W'(PAT_W - 1));
                    if (hit) begin
                        pulse_d = 1'b1;
                        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                        // Non-overlap mode demands a full pattern of fresh bits.
                        if (!cfg_ov_q) fill_d = '0;
`ifdef FIRST_MATCH_POS_EN
                        if (!fpos_vld_q) begin
                            fpos_d     = win_cnt_d;
                            fpos_vld_d = 1'b1;
                        end
`endif
                    end
                    thr_reached = (cfg_thr_q != '0) && (cnt_d == cfg_thr_q);
                    win_reached = (cfg_win_q != '0) && (win_cnt_d == cfg_win_q);
                end
                if (thr_reached) thr_hit_d = 1'b1;
                if (stop || thr_reached || win_reached) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: config registers are reset too, so a start right after reset runs a known pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            win_cnt_q <= '0;
            pulse_q   <= 1'b0;
            thr_hit_q <= 1'b0;
            cfg_pat_q <= '0;
            cfg_ov_q  <= 1'b1;
            cfg_thr_q <= '0;
            cfg_win_q <= '0;
`ifdef FIRST_MATCH_POS_EN
            fpos_q     <= '0;
            fpos_vld_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            win_cnt_q <= win_cnt_d;
            pulse_q   <= pulse_d;
            thr_hit_q <= thr_hit_d;
            cfg_pat_q <= cfg_pat_d;
            cfg_ov_q  <= cfg_ov_d;
            cfg_thr_q <= cfg_thr_d;
            cfg_win_q <= cfg_win_d;
`ifdef FIRST_MATCH_POS_EN
            fpos_q     <= fpos_d;
            fpos_vld_q <= fpos_vld_d;
`endif
        end
    end

    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign match_pulse   = pulse_q;
    assign match_count   = cnt_q;
    assign threshold_hit = thr_hit_q;
`ifdef FIRST_MATCH_POS_EN
    assign first_pos       = fpos_q;
    assign first_pos_valid = fpos_vld_q;
`endif

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Run-control and configuration block for a programmable serial pattern detector.
- Holds a PAT_W-bit target pattern and an overlap/non-overlap mode, and scans a qualified bit stream for that pattern.
- Counts matches and ends a detection run on stop, an observation-window limit or a match-count threshold.
- Sits between a host configuration interface and the serial bit source.

Parameters:
PAT_W, 3, pattern length in bits (>=2)
CNT_W, 8, match counter width
WIN_W, 16, observation-window counter width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
cfg_we  input  1  config write strobe, honoured only in IDLE or DONE
cfg_pattern  input  PAT_W  target pattern, MSB = oldest bit
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_threshold  input  CNT_W  match count that ends the run; 0 = disabled
cfg_window  input  WIN_W  number of accepted bits that ends the run; 0 = unlimited
start  input  1  begin a run (1-cycle pulse)
stop  input  1  abort a run (1-cycle pulse)
bit_valid  input  1  bit_in is valid this cycle
bit_in  input  1  serial data bit
busy  output  1  high while in RUN
match_pulse  output  1  1-cycle pulse per detected match
match_count  output  CNT_W  matches in the current or last run
done  output  1  high in DONE
threshold_hit  output  1  last run ended on threshold

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All outputs are 0.
  - History shift register and counters are 0.
  - Config resets to pattern=0, overlap=1, threshold=0, window=0.
- FSM states are IDLE, RUN and DONE. All outputs are registered.
- IDLE: start=1 moves to RUN. The same edge clears history, fill count, match_count, window count and threshold_hit.
- DONE: done=1 and outputs hold. start=1 moves to RUN with the same clearing as from IDLE.
- Config: cfg_we in IDLE or DONE loads all cfg_* fields at the edge. cfg_we in RUN is ignored.
- start while in RUN is ignored. stop outside RUN is ignored.
- RUN, per edge with bit_valid=1 (an accepted bit):
  - The new window is w = {history[PAT_W-2:0], bit_in}.
  - history <= w.
  - The fill count increments and saturates at PAT_W.
  - The window count increments.
- Match condition: w == cfg_pattern AND the pre-increment fill count >= PAT_W-1.
- On a match:
  - match_pulse=1 in the following cycle.
  - match_count increments and saturates at all-ones.
  - If cfg_overlap=0, the fill count resets to 0, so the next match needs PAT_W fresh bits.
- bit_valid=0 in RUN changes nothing. match_pulse is 0 in any cycle not following a match.
- Run termination is evaluated at the same edge as the accepted bit, after that bit is counted. The FSM moves to DONE when any of these holds:
  - stop=1
  - threshold!=0 and the new match_count == threshold; this sets threshold_hit=1
  - window!=0 and the new window count == window
- Simultaneous events:
  - stop together with bit_valid: the bit is processed and counted, then DONE.
  - Threshold and window reached on the same bit: threshold_hit=1.
- Bits arriving in IDLE or DONE are ignored.
- busy is 0 and done is 1 from the cycle after the terminating edge.
- Window-count wrap: cfg_window=0 lets the window count wrap freely, with no effect.

Optional Feature:
- Macro FIRST_MATCH_POS_EN.
- When defined, two outputs are added:
  - first_pos [WIN_W-1:0]: the window count (1-based) of the bit completing the first match of the run.
  - first_pos_valid: set with that first match, held through DONE, cleared on start or reset.
- When undefined, neither port nor its logic exists, and behaviour is otherwise identical.

Test Plan:
- Overlap mode: cfg pattern=101, overlap=1, threshold=0, window=0; start; bits 1,0,1,0,1 -> match_pulse after bits 3 and 5; match_count=2; busy=1.
- Non-overlap mode: same stream with overlap=0 -> single match_pulse after bit 3; match_count=1.
- Threshold stop: pattern=110, overlap=1, threshold=2; bits 1,1,0,1,1,0,1,0 -> matches at bits 3 and 6; DONE after bit 6 with threshold_hit=1, busy=0; bits 7-8 ignored; count=2.
- Window stop: pattern=111, window=4; bits 1,1,1,1,1 -> matches at bits 3 and 4; count=2; DONE after bit 4 with threshold_hit=0; bit 5 ignored. With FIRST_MATCH_POS_EN: first_pos=3, first_pos_valid=1.
- Control corner cases:
  - cfg_we in RUN does not change the pattern.
  - start in RUN leaves count unchanged.
  - stop with bit_valid and a matching bit -> count includes that match, then DONE.
  - start from DONE clears count to 0.
- Reset mid-run: reset_n=0 after 2 matches -> all outputs 0 immediately; after release, a start with no new cfg_we uses pattern=000 and overlap=1.
